// File: rtl/mmio_bus_initiator.sv
// mmio_bus_initiator: host-side initiator for the single-word MMIO request/response bus.
// Takes one command at a time on a valid/ready port, issues exactly one single-cycle
// read or write request, waits for the matching response and reports the outcome on
// a one-cycle response pulse. All outputs come straight from flops.
// Optional feature: define MMIO_INITIATOR_TIMEOUT_EN to abort a transaction with an
// error after TIMEOUT_CYCLES silent WAIT cycles. Without it, WAIT persists until the
// matching response or reset.
module mmio_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_write_data,
    input  logic [3:0]  cmd_strobe,
    // response port
    output logic        rsp_valid,
    output logic [31:0] rsp_read_data,
    output logic        rsp_error,
    // MMIO bus
    output logic [31:0] rw_address,
    input  logic [31:0] read_data,
    output logic        read_request,
    input  logic        read_response,
    output logic [31:0] write_data,
    output logic [3:0]  write_strobe,
    output logic        write_request,
    input  logic        write_response
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // A zero timeout would abort every transaction before any responder could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mmio_bus_initiator: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_read_data_q, rsp_read_data_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rw_address_q, rw_address_d;
    logic        read_request_q, read_request_d;
    logic [31:0] write_data_q, write_data_d;
    logic [3:0]  write_strobe_q, write_strobe_d;
    logic        write_request_q, write_request_d;
    logic        match_response;

`ifdef MMIO_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Count value seen during the last permitted silent WAIT cycle.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_count_q, wait_count_d;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
    assign rsp_error     = rsp_error_q;
    assign rw_address    = rw_address_q;
    assign read_request  = read_request_q;
    assign write_data    = write_data_q;
    assign write_strobe  = write_strobe_q;
    assign write_request = write_request_q;

    // Only the response that matches the outstanding request type counts.
    assign match_response = is_write_q ? write_response : read_response;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d         = state_q;
        is_write_d      = is_write_q;
        cmd_ready_d     = cmd_ready_q;
        rsp_valid_d     = 1'b0;
        rsp_read_data_d = rsp_read_data_q;
        rsp_error_d     = rsp_error_q;
        rw_address_d    = rw_address_q;
        read_request_d  = 1'b0;
        write_data_d    = write_data_q;
        write_strobe_d  = write_strobe_q;
        write_request_d = 1'b0;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
        wait_count_d    = wait_count_q;
`endif

        unique case (state_q)
            IDLE: begin
                cmd_ready_d     = 1'b1;
                rsp_read_data_d = '0;
                rsp_error_d     = 1'b0;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    is_write_d  = cmd_write;
                    if (cmd_address[1:0] == 2'b00) begin
                        // Latch the command straight into the bus registers so the
                        // request cycle already presents a complete, stable beat.
                        state_d         = REQ;
                        rw_address_d    = cmd_address;
                        write_data_d    = cmd_write ? cmd_write_data : '0;
                        write_strobe_d  = cmd_write ? cmd_strobe : 4'b0000;
                        read_request_d  = ~cmd_write;
                        write_request_d = cmd_write;
                    end else begin
                        // Misaligned: report the error without touching the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end

            REQ, WAIT: begin
                cmd_ready_d = 1'b0;
                if (match_response) begin
                    state_d         = RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_error_d     = 1'b0;
                    rsp_read_data_d = is_write_q ? '0 : read_data;
                    rw_address_d    = '0;
                    write_data_d    = '0;
                    write_strobe_d  = 4'b0000;
                end else if (state_q == REQ) begin
                    state_d = WAIT;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
                    wait_count_d = '0;
`endif
                end
`ifdef MMIO_INITIATOR_TIMEOUT_EN
                else if (wait_count_q == TIMEOUT_LAST) begin
                    // Responder stayed silent too long; give up with an error.
                    state_d         = RESP;
                    rsp_valid_d     = 1'b1;
                    rsp_error_d     = 1'b1;
                    rsp_read_data_d = '0;
                    rw_address_d    = '0;
                    write_data_d    = '0;
                    write_strobe_d  = 4'b0000;
                end else begin
                    wait_count_d = wait_count_q + 1'b1;
                end
`endif
            end

            RESP: begin
                state_d         = IDLE;
                cmd_ready_d     = 1'b1;
                rsp_read_data_d = '0;
                rsp_error_d     = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            is_write_q      <= 1'b0;
            cmd_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_read_data_q <= '0;
            rsp_error_q     <= 1'b0;
            rw_address_q    <= '0;
            read_request_q  <= 1'b0;
            write_data_q    <= '0;
            write_strobe_q  <= 4'b0000;
            write_request_q <= 1'b0;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
            wait_count_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            is_write_q      <= is_write_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_read_data_q <= rsp_read_data_d;
            rsp_error_q     <= rsp_error_d;
            rw_address_q    <= rw_address_d;
            read_request_q  <= read_request_d;
            write_data_q    <= write_data_d;
            write_strobe_q  <= write_strobe_d;
            write_request_q <= write_request_d;
`ifdef MMIO_INITIATOR_TIMEOUT_EN
            wait_count_q    <= wait_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Self-checking bench for mmio_bus_initiator: directed command sequence, a bus
// responder with programmable latency, a response scoreboard and a bus monitor.
module tb_mmio_bus_initiator;

`ifdef MMIO_INITIATOR_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_address = '0;
    logic [31:0] cmd_write_data = '0;
    logic [3:0]  cmd_strobe = '0;
    logic        rsp_valid;
    logic [31:0] rsp_read_data;
    logic        rsp_error;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;

    always #5 clock = ~clock;

    mmio_bus_initiator #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_write_data(cmd_write_data), .cmd_strobe(cmd_strobe),
        .rsp_valid(rsp_valid), .rsp_read_data(rsp_read_data), .rsp_error(rsp_error),
        .rw_address(rw_address), .read_data(read_data), .read_request(read_request),
        .read_response(read_response), .write_data(write_data), .write_strobe(write_strobe),
        .write_request(write_request), .write_response(write_response)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // ---------------- responder ----------------
    int          lat = 1;
    bit          silent = 1'b0;
    bit          inj_rd = 1'b0;
    bit          inj_wr = 1'b0;
    logic [31:0] rdata_val = '0;
    int          pend = 0;
    bit          pend_w = 1'b0;

    always @(posedge clock) begin
        if ((read_request || write_request) && lat > 0) begin
            pend   <= lat;
            pend_w <= write_request;
        end else if (pend > 0) begin
            pend <= pend - 1;
        end
    end

    assign read_response  = inj_rd | (!silent && ((lat == 0) ? read_request : (pend == 1 && !pend_w)));
    assign write_response = inj_wr | (!silent && ((lat == 0) ? write_request : (pend == 1 && pend_w)));
    assign read_data      = read_response ? rdata_val : 32'hBAD0_BAD0;

    // ---------------- scoreboard and bus monitor ----------------
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int          rsp_cnt = 0;
    int          req_cnt = 0;
    int          last_rsp_cyc = 0;
    int          req_cycs[$];
    bit          bus_open = 1'b0;
    bit          prev_req = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;
    logic [3:0]  exp_strb = '0;
    logic        exp_is_wr = 1'b0;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) bus_open = 1'b0;
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            bus_open = 1'b0;
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL rsp_unexpected: observed rsp_valid=1 expected no response");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_error", rsp_error, e.err);
                check("rsp_read_data", rsp_read_data, e.data);
            end
            $display("rsp cyc=%0d err=%0b data=%h", cyc, rsp_error, rsp_read_data);
        end
        if (read_request || write_request) begin
            check("req_onehot", read_request & write_request, 0);
            check("req_width", prev_req, 0);
            check("req_kind", write_request, exp_is_wr);
            check("req_addr", rw_address, exp_addr);
            check("req_wdata", write_data, exp_wdata);
            check("req_strobe", write_strobe, exp_strb);
            req_cnt++;
            req_cycs.push_back(cyc);
            bus_open = 1'b1;
        end else if (bus_open) begin
            check("hold_addr", rw_address, exp_addr);
            check("hold_wdata", write_data, exp_wdata);
            check("hold_strobe", write_strobe, exp_strb);
        end
        if (bus_open && (exp_is_wr ? write_response : read_response)) bus_open = 1'b0;
        prev_req = read_request | write_request;
    end

    // One complete command: expected latency is rsp_valid cycle minus the
    // cycle right after the accepting edge (where the request pulse appears).
    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, input int exp_reqs);
        int acc, r0, q0, n;
        exp_t e;
        check({tag, "_ready"}, cmd_ready, 1);
        exp_addr  = addr;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        exp_is_wr = wr;
        e.err = exp_err;
        e.data = exp_rdata;
        sb.push_back(e);
        r0 = rsp_cnt;
        q0 = req_cnt;
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
        cmd_write_data = wdata; cmd_strobe = strb;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt == r0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_rsp_seen"}, rsp_cnt - r0, 1);
        check({tag, "_latency"}, last_rsp_cyc - acc, exp_lat);
        check({tag, "_req_count"}, req_cnt - q0, exp_reqs);
        check({tag, "_ready_in_rsp"}, cmd_ready, 0);
        tick();
        check({tag, "_ready_after"}, cmd_ready, 1);
        $display("cmd %s wr=%0b addr=%h accepted cyc=%0d", tag, wr, addr, acc);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r0, q0, n;
        exp_t e;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_read_data, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_address", rw_address, 0);
        check("rst_rd_req", read_request, 0);
        check("rst_wdata", write_data, 0);
        check("rst_strobe", write_strobe, 0);
        check("rst_wr_req", write_request, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", cmd_ready, 1);

        // 1: aligned read, 1-cycle responder; write data/strobe must be zeroed on the bus
        lat = 1; rdata_val = 32'h1234_5678;
        run_cmd("read4", 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h1234_5678, 2, 1);

        // 2: write with a 3-cycle responder so the bus must hold through WAIT
        lat = 3;
        run_cmd("writeC", 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 4, 1);

        // 3: misaligned read never reaches the bus
        run_cmd("misalign", 1'b0, 32'h0000_0006, 32'h0, 4'h0, 1'b1, 32'h0, 0, 0);

        // 5: zero-latency responder (response together with the request)
        lat = 0; rdata_val = 32'hCAFE_F00D;
        run_cmd("read_l0", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1, 1);
        run_cmd("write_l0", 1'b1, 32'h0000_0104, 32'h0BAD_CAFE, 4'h5, 1'b0, 32'h0, 1, 1);

`ifdef MMIO_INITIATOR_TIMEOUT_EN
        // 4: silent responder times out after TB_TIMEOUT WAIT cycles
        lat = 1; silent = 1'b1;
        run_cmd("timeout", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'h0, TB_TIMEOUT + 1, 1);
        silent = 1'b0;
        r0 = rsp_cnt; q0 = req_cnt;
        inj_wr = 1'b1;
        tick();
        inj_wr = 1'b0;
        repeat (3) tick();
        check("stale_no_rsp", rsp_cnt - r0, 0);
        check("stale_no_req", req_cnt - q0, 0);
        // response in the very cycle the timeout would fire wins
        lat = TB_TIMEOUT; rdata_val = 32'h5555_AAAA;
        run_cmd("to_race", 1'b0, 32'h0000_0024, 32'h0, 4'h0, 1'b0, 32'h5555_AAAA, TB_TIMEOUT + 1, 1);
        // one cycle later is too late: error, and the late response is ignored
        lat = TB_TIMEOUT + 1;
        run_cmd("to_late", 1'b1, 32'h0000_0028, 32'h1111_2222, 4'h3, 1'b1, 32'h0, TB_TIMEOUT + 1, 1);
        lat = 1; rdata_val = 32'h0F0F_0F0F;
        run_cmd("after_to", 1'b0, 32'h0000_002C, 32'h0, 4'h0, 1'b0, 32'h0F0F_0F0F, 2, 1);
`else
        // 5: slow responder waits indefinitely without a timeout
        lat = 10; rdata_val = 32'hA5A5_5A5A;
        run_cmd("read_l10", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 32'hA5A5_5A5A, 11, 1);
`endif

        // 6: back-to-back commands with cmd_valid held high
        lat = 1;
        req_cycs.delete();
        r0 = rsp_cnt;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (cmd_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            exp_is_wr = (k == 1);
            exp_addr  = 32'h0000_0010 + 32'(4 * k);
            exp_wdata = (k == 1) ? 32'h7777_8888 : 32'h0;
            exp_strb  = (k == 1) ? 4'hC : 4'h0;
            rdata_val = 32'h3000_0000 + 32'(k);
            e.err  = 1'b0;
            e.data = (k == 1) ? 32'h0 : rdata_val;
            sb.push_back(e);
            cmd_valid = 1'b1; cmd_write = (k == 1); cmd_address = exp_addr;
            cmd_write_data = 32'h7777_8888; cmd_strobe = 4'hC;
            tick();
            $display("cmd b2b%0d accepted cyc=%0d", k, cyc);
        end
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_cnt - r0 < 3 && n < 40) begin
            tick();
            n++;
        end
        check("b2b_rsp_count", rsp_cnt - r0, 3);
        check("b2b_req_count", req_cycs.size(), 3);
        if (req_cycs.size() == 3) begin
            check("b2b_spacing0", req_cycs[1] - req_cycs[0], 4);
            check("b2b_spacing1", req_cycs[2] - req_cycs[1], 4);
        end
        repeat (2) tick();

        // 6: reset while waiting; the responder answers after reset and must be ignored
        lat = 3;
        exp_is_wr = 1'b0; exp_addr = 32'h0000_0030; exp_wdata = 32'h0; exp_strb = 4'h0;
        check("rst_mid_ready", cmd_ready, 1);
        r0 = rsp_cnt; q0 = req_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h0000_0030;
        tick();
        cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_rd_req", read_request, 0);
        check("rst_mid_wr_req", write_request, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 0);
        check("rst_mid_address", rw_address, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("rst_mid_no_rsp", rsp_cnt - r0, 0);
        check("rst_mid_one_req", req_cnt - q0, 1);
        check("rst_mid_ready_after", cmd_ready, 1);
        $display("reset mid-transaction done cyc=%0d", cyc);

        lat = 1; rdata_val = 32'h600D_600D;
        run_cmd("after_rst", 1'b0, 32'h0000_0034, 32'h0, 4'h0, 1'b0, 32'h600D_600D, 2, 1);
        check("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
